power_status_tx: RTL and testbench

Reports the four power-control enable levels back over the UART link as 2-byte ASCII frames. It uses the same letter-digit command set that the host sends down ("A1"/"A0", "B1"/"B0", "D1"/"D0", "E1"/"E0"). The block sits between the power-control state registers and the UART byte transmitter. It sends one frame whenever a channel level changes, and optionally sends all four channels periodically as a heartbeat.

---
 rtl/power_pkg.sv | 48 ++++
 rtl/power_hb_timer.sv | 43 ++++
 rtl/power_status_tx.sv | 147 ++++++++++++++
 tb/tb_power_status_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/power_pkg.sv
// -----------------------------------------------------------------------------
// power_pkg
// Constants and types shared by the power-control uplink (power_status_tx)
// and the downlink command decoder: channel letters, level digits, the
// uplink FSM state encoding and the 2-bit channel index type.
// Channel index order: 0 = lift (A), 1 = lower (B), 2 = extend (D),
// 3 = retract (E).
// -----------------------------------------------------------------------------
package power_pkg;

    typedef logic [1:0] chan_idx_t;

    localparam int unsigned NUM_CHANNELS = 4;

    localparam logic [7:0] CH_LETTER_A = 8'h41;
    localparam logic [7:0] CH_LETTER_B = 8'h42;
    localparam logic [7:0] CH_LETTER_D = 8'h44;
    localparam logic [7:0] CH_LETTER_E = 8'h45;

    localparam logic [7:0] DIGIT_0 = 8'h30;
    localparam logic [7:0] DIGIT_1 = 8'h31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HI,
        ST_WAIT_HI,
        ST_SEND_LO,
        ST_WAIT_LO
    } tx_state_t;

    // Map a channel index to its ASCII command letter.
    function automatic logic [7:0] chan_letter(input chan_idx_t idx);
        logic [7:0] letter;
        case (idx)
            2'd0:    letter = CH_LETTER_A;
            2'd1:    letter = CH_LETTER_B;
            2'd2:    letter = CH_LETTER_D;
            default: letter = CH_LETTER_E;
        endcase
        return letter;
    endfunction

    // Map a level bit to its ASCII digit.
    function automatic logic [7:0] level_digit(input logic level);
        return level ? DIGIT_1 : DIGIT_0;
    endfunction

endpackage

// File: rtl/power_hb_timer.sv
// -----------------------------------------------------------------------------
// power_hb_timer
// Free-running heartbeat counter for power_status_tx. Counts 0..HEARTBEAT-1
// and raises hb_wrap for the single cycle in which the count is HEARTBEAT-1.
// With HEARTBEAT = 0 no counter is built and hb_wrap is tied low.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset (counter back to 0)
//   hb_wrap  one-cycle pulse on the wrap cycle
// -----------------------------------------------------------------------------
module power_hb_timer #(
    parameter int unsigned HEARTBEAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    output logic hb_wrap
);

    generate
        if (HEARTBEAT == 0) begin : g_off
            // Clock and reset are deliberately left without a load here.
            logic unused_inputs;
            assign unused_inputs = clk ^ rst_n;
            assign hb_wrap = 1'b0;
        end else begin : g_on
            logic [31:0] cnt_reg;

            assign hb_wrap = (cnt_reg == 32'(HEARTBEAT - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (hb_wrap) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/power_status_tx.sv
// -----------------------------------------------------------------------------
// power_status_tx
// Reports the four power-control enable levels to the host as 2-byte ASCII
// frames ("A1", "B0", "D1", "E0", ...). A frame is queued whenever a level
// changes, and optionally all four channels are queued on every heartbeat.
// Pending channels are served round-robin; each frame carries the level
// sampled at the moment the channel was granted.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_state  enable levels: [0]=A lift, [1]=B lower, [2]=D extend, [3]=E retract
//   tx_done    one-cycle pulse from the UART when the current byte is sent
//   tx_data    byte to transmit, held until the next tx_start
//   tx_start   one-cycle send request to the UART
// -----------------------------------------------------------------------------
module power_status_tx
    import power_pkg::*;
#(
    parameter int unsigned HEARTBEAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_state,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start
);

    genvar gi;

    logic [3:0] prev_state_reg;
    logic [3:0] pending_reg;
    logic [3:0] pending_next;
    logic [3:0] set_vec;
    logic [3:0] clear_vec;
    logic [3:0] rot_pending;

    chan_idx_t  ptr_reg;        // first channel to examine on the next grant
    chan_idx_t  chan_reg;       // channel of the frame in flight
    logic       snap_reg;       // level of that channel captured at grant
    tx_state_t  state_reg;
    logic       tx_start_reg;
    logic [7:0] tx_data_reg;

    chan_idx_t  grant_off;
    chan_idx_t  grant_idx;
    logic       do_grant;
    logic       hb_wrap;

    power_hb_timer #(
        .HEARTBEAT (HEARTBEAT)
    ) u_hb_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .hb_wrap (hb_wrap)
    );

    // A channel needs reporting when its level moved or a heartbeat fires.
    assign set_vec  = (key_state ^ prev_state_reg) | {4{hb_wrap}};
    assign do_grant = (state_reg == ST_IDLE) && (|pending_reg);

    // Rotate the pending vector so that bit 0 is the round-robin start point.
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            localparam chan_idx_t CH = chan_idx_t'(gi);

            assign rot_pending[gi] = pending_reg[ptr_reg + CH];
            assign clear_vec[gi]   = do_grant && (grant_idx == CH);
            // A set on the grant edge beats the clear so no change is lost.
            assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clear_vec[gi]);
        end
    endgenerate

    // Lowest set bit of the rotated vector is the next channel in turn.
    always_comb begin
        grant_off = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (rot_pending[i]) begin
                grant_off = chan_idx_t'(i);
            end
        end
    end

    assign grant_idx = ptr_reg + grant_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_reg <= '0;
            pending_reg    <= '0;
        end else begin
            prev_state_reg <= key_state;
            pending_reg    <= pending_next;
        end
    end

    // Frame FSM; tx_start/tx_data are registered from the SEND states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            chan_reg     <= '0;
            snap_reg     <= 1'b0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (do_grant) begin
                        chan_reg  <= grant_idx;
                        snap_reg  <= key_state[grant_idx];
                        ptr_reg   <= grant_idx + chan_idx_t'(1);
                        state_reg <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    tx_start_reg <= 1'b1;
                    tx_data_reg  <= chan_letter(chan_reg);
                    state_reg    <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (tx_done) begin
                        state_reg <= ST_SEND_LO;
                    end
                end
                ST_SEND_LO: begin
                    tx_start_reg <= 1'b1;
                    tx_data_reg  <= level_digit(snap_reg);
                    state_reg    <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (tx_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_power_status_tx.sv
// -----------------------------------------------------------------------------
// tb_power_status_tx
// Two instances: u_dut_a (no heartbeat) for change-driven frames and reset,
// u_dut_b (HEARTBEAT=1000) for the periodic dump. Each has a UART model that
// answers every tx_start with a tx_done pulse 100 cycles later and records
// the transmitted bytes.
// -----------------------------------------------------------------------------
module tb_power_status_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_hb_n;
    logic [3:0] key_a;
    logic [3:0] key_b;
    logic       done_a;
    logic       done_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       start_a;
    logic       start_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    byte unsigned a_q[$];
    byte unsigned b_q[$];
    int           b_t[$];
    int           a_cnt, b_cnt;
    int           a_last_done, b_last_done;

    typedef struct {
        logic [3:0]  key;
        int          nbytes;
        logic [63:0] exp;   // expected ASCII stream, right-justified
    } vec_t;

    vec_t vecs[7];

    power_status_tx #(.HEARTBEAT(0)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_state (key_a),
        .tx_done   (done_a),
        .tx_data   (data_a),
        .tx_start  (start_a)
    );

    power_status_tx #(.HEARTBEAT(1000)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_hb_n),
        .key_state (key_b),
        .tx_done   (done_b),
        .tx_data   (data_b),
        .tx_start  (start_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART model + byte capture for instance A.
    always @(negedge clk) begin
        if (!rst_n) begin
            a_cnt  = 0;
            done_a = 1'b0;
        end else begin
            done_a = 1'b0;
            if (a_cnt > 0) begin
                a_cnt--;
                if (a_cnt == 0) begin
                    done_a      = 1'b1;
                    a_last_done = cyc;
                end
            end
            if (start_a) begin
                a_q.push_back(data_a);
                $display("A byte 0x%02h '%c' at cycle %0d", data_a, data_a, cyc);
                if (data_a == 8'h30 || data_a == 8'h31)
                    chk("a digit spacing after tx_done", cyc - a_last_done, 2);
                a_cnt = 100;
            end
        end
    end

    // UART model + byte capture for instance B.
    always @(negedge clk) begin
        if (!rst_hb_n) begin
            b_cnt  = 0;
            done_b = 1'b0;
        end else begin
            done_b = 1'b0;
            if (b_cnt > 0) begin
                b_cnt--;
                if (b_cnt == 0) begin
                    done_b      = 1'b1;
                    b_last_done = cyc;
                end
            end
            if (start_b) begin
                b_q.push_back(data_b);
                b_t.push_back(cyc);
                $display("B byte 0x%02h '%c' at cycle %0d", data_b, data_b, cyc);
                if (data_b == 8'h30 || data_b == 8'h31)
                    chk("b digit spacing after tx_done", cyc - b_last_done, 2);
                b_cnt = 100;
            end
        end
    end

    task automatic wait_a(input int target, input int budget, input string name);
        int n = 0;
        while (a_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (a_q.size() < target) chk({name, " timeout"}, a_q.size(), target);
    endtask

    task automatic wait_b(input int target, input int budget, input string name);
        int n = 0;
        while (b_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (b_q.size() < target) chk({name, " timeout"}, b_q.size(), target);
    endtask

    initial begin
        int    base;
        int    rel;
        string hb_exp;

        // Round-robin pointer evolution is traced by hand in the comments.
        vecs[0] = '{4'b0001, 2, 64'("A1")};        // ptr -> 1
        vecs[1] = '{4'b0000, 2, 64'("A0")};        // ptr -> 1
        vecs[2] = '{4'b1010, 4, 64'("B1E1")};      // ptr -> 0
        vecs[3] = '{4'b1110, 2, 64'("D1")};        // ptr -> 3
        vecs[4] = '{4'b0100, 4, 64'("E0B0")};      // from E: E then B, ptr -> 2
        vecs[5] = '{4'b1011, 8, 64'("D0E1A1B1")};  // from D, ptr -> 2
        vecs[6] = '{4'b0000, 6, 64'("E0A0B0")};    // from D(idle): E, A, B, ptr -> 2

        rst_n    = 1'b0;
        rst_hb_n = 1'b0;
        key_a    = 4'b0000;
        key_b    = 4'b0000;
        done_a   = 1'b0;
        done_b   = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset tx_start", int'(start_a), 0);
        chk("reset tx_data", int'(data_a), 8'h00);
        rst_n = 1'b1;

        // Quiet after reset.
        repeat (2000) @(negedge clk);
        chk("quiet after reset byte count", a_q.size(), 0);

        // Table-driven change frames.
        for (int v = 0; v < 7; v++) begin
            base  = a_q.size();
            key_a = vecs[v].key;
            wait_a(base + vecs[v].nbytes, 3000, $sformatf("vec%0d", v));
            repeat (300) @(negedge clk);
            chk($sformatf("vec%0d byte count", v), a_q.size(), base + vecs[v].nbytes);
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                if (base + i < a_q.size())
                    chk($sformatf("vec%0d byte %0d", v, i), int'(a_q[base + i]),
                        int'(vecs[v].exp[8*(vecs[v].nbytes - 1 - i) +: 8]));
            end
        end

        // Change during a frame: D pulses high for one cycle while "A1" is in flight.
        base  = a_q.size();
        key_a = 4'b0001;
        wait_a(base + 1, 500, "midframe first byte");
        repeat (20) @(negedge clk);
        key_a = 4'b0101;
        @(negedge clk);
        key_a = 4'b0001;
        wait_a(base + 4, 3000, "midframe frames");
        repeat (300) @(negedge clk);
        chk("midframe byte count", a_q.size(), base + 4);
        if (a_q.size() >= base + 4) begin
            chk("midframe byte0", int'(a_q[base]), 8'h41);
            chk("midframe byte1", int'(a_q[base + 1]), 8'h31);
            chk("midframe byte2", int'(a_q[base + 2]), 8'h44);
            chk("midframe byte3", int'(a_q[base + 3]), 8'h30);
        end

        // Bring A back to 0 before the reset scenario.
        base  = a_q.size();
        key_a = 4'b0000;
        wait_a(base + 2, 3000, "A0 before reset");
        repeat (300) @(negedge clk);
        chk("A0 before reset count", a_q.size(), base + 2);

        // Reset in WAIT_HI of an "A1" frame.
        base  = a_q.size();
        key_a = 4'b0001;
        wait_a(base + 1, 500, "reset frame first byte");
        if (a_q.size() > base) chk("reset frame letter", int'(a_q[base]), 8'h41);
        repeat (10) @(negedge clk);
        key_a = 4'b0000;
        rst_n = 1'b0;
        #1;
        chk("async reset tx_start", int'(start_a), 0);
        chk("async reset tx_data", int'(data_a), 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        chk("no bytes after mid-frame reset", a_q.size(), base + 1);

        // Heartbeat: make E the last channel served, then two full dumps.
        @(negedge clk);
        rst_hb_n = 1'b1;
        rel      = cyc;
        repeat (5) @(negedge clk);
        key_b = 4'b1101;                     // A1, D1, E1 -> ptr 0
        wait_b(6, 1000, "hb setup frames");
        key_b = 4'b0101;                     // E0 -> ptr 0
        wait_b(8, 500, "hb E0 frame");
        wait_b(24, 3000, "hb dumps");
        repeat (100) @(negedge clk);
        hb_exp = "A1D1E1E0A1B0D1E0A1B0D1E0";
        chk("hb byte count", b_q.size(), 24);
        for (int i = 0; i < 24; i++) begin
            if (i < b_q.size())
                chk($sformatf("hb byte %0d", i), int'(b_q[i]), int'(hb_exp[i]));
        end
        // Wrap at count 999 -> pending on edge 1000 -> SEND_HI 1001 -> tx_start 1002.
        if (b_t.size() > 8) chk("hb first dump start cycle", b_t[8] - rel, 1002);
        if (b_t.size() > 16) chk("hb second dump start cycle", b_t[16] - rel, 2002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
